// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin channel arbiter.
package rr_arb_pkg;

  localparam int DEFAULT_TIMEOUT = 8;

  typedef logic [2:0] state_t;

  localparam state_t S_SELECT  = 3'd0;
  localparam state_t S_FETCH   = 3'd1;
  localparam state_t S_DRAIN   = 3'd2;
  localparam state_t S_HOLD    = 3'd3;
  localparam state_t S_RELEASE = 3'd4;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Circular priority search: first set bit of mask at or after start.
module rr_next_sel
  import rr_arb_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_CH-1:0]   mask,
  input  logic [ID_WIDTH-1:0] start,
  output logic [ID_WIDTH-1:0] sel,
  output logic                any
);

  int idx;

  always_comb begin
    // NOTE: every output gets a default before the search so no path can infer a latch.
    sel = '0;
    any = 1'b0;
    idx = 0;
    // Walk from the farthest offset down so the nearest enabled channel is written last.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (mask[idx]) begin
        sel = ID_WIDTH'(idx);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_channel_arbiter.sv
// Round-robin merger of NUM_CH req/ack source channels onto one id-tagged sink channel.
// Define RR_ARB_STATS_EN to add the grant_count and timeout_count outputs.
module rr_channel_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int TIMEOUT    = DEFAULT_TIMEOUT,
  localparam int ID_WIDTH   = id_width(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            chan_en,
  output logic [NUM_CH-1:0]            src_req,
  input  logic [NUM_CH-1:0]            src_ack,
  input  logic [NUM_CH*DATA_WIDTH-1:0] src_din,
  input  logic                         snk_req,
  output logic                         snk_ack,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic [ID_WIDTH-1:0]          dout_id
`ifdef RR_ARB_STATS_EN
  ,
  output logic [31:0]                  grant_count,
  output logic [31:0]                  timeout_count
`endif
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT);

  state_t                  state;
  logic [ID_WIDTH-1:0]     ptr;
  logic [CNT_WIDTH-1:0]    cnt;
  logic [ID_WIDTH-1:0]     nxt;
  logic                    any_en;
  logic                    sel_ack;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    capture;

  function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] p);
    return (p == ID_WIDTH'(NUM_CH - 1)) ? '0 : p + 1'b1;
  endfunction

  rr_next_sel #(
    .NUM_CH   (NUM_CH),
    .ID_WIDTH (ID_WIDTH)
  ) u_next_sel (
    .mask  (chan_en),
    .start (ptr),
    .sel   (nxt),
    .any   (any_en)
  );

  assign sel_ack  = src_ack[ptr];
  assign sel_data = src_din[int'(ptr)*DATA_WIDTH +: DATA_WIDTH];
  // A late ack in DRAIN is captured exactly like a regular one so no token is lost.
  assign capture  = sel_ack && (state == S_FETCH || state == S_DRAIN);

  // NOTE: sequential state uses non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_SELECT;
      ptr     <= '0;
      cnt     <= '0;
      src_req <= '0;
      snk_ack <= 1'b0;
      dout    <= '0;
      dout_id <= '0;
    end else if (capture) begin
      dout    <= sel_data;
      dout_id <= ptr;
      src_req <= '0;
      state   <= S_HOLD;
    end else begin
      unique case (state)
        S_SELECT: begin
          src_req <= '0;
          if (any_en) begin
            ptr     <= nxt;
            src_req <= NUM_CH'(1) << nxt;
            cnt     <= '0;
            state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (cnt == CNT_WIDTH'(TIMEOUT - 1)) begin
            src_req <= '0;
            state   <= S_DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          ptr   <= wrap_inc(ptr);
          state <= S_SELECT;
        end
        S_HOLD: begin
          if (snk_req) begin
            snk_ack <= 1'b1;
            state   <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          snk_ack <= 1'b0;
          ptr     <= wrap_inc(dout_id);
          state   <= S_SELECT;
        end
        default: state <= S_SELECT;
      endcase
    end
  end

`ifdef RR_ARB_STATS_EN
  logic drain_miss;
  assign drain_miss = (state == S_DRAIN) && !sel_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_count   <= '0;
      timeout_count <= '0;
    end else begin
      if (capture)    grant_count   <= grant_count + 32'd1;
      if (drain_miss) timeout_count <= timeout_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rr_channel_arbiter.sv
// Self-checking bench for rr_channel_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_rr_channel_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int TO  = 8;
  localparam int IDW = 2;

  localparam int M_IMM   = 0;
  localparam int M_NEVER = 1;
  localparam int M_LATE  = 2;
  localparam int M_RAND  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    chan_en = '1;
  logic [N-1:0]    src_req;
  logic [N-1:0]    src_ack;
  logic [N*DW-1:0] src_din;
  logic            snk_req;
  logic            snk_ack;
  logic [DW-1:0]   dout;
  logic [IDW-1:0]  dout_id;
`ifdef RR_ARB_STATS_EN
  logic [31:0]     grant_count;
  logic [31:0]     timeout_count;
`endif

  rr_channel_arbiter #(
    .NUM_CH     (N),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .chan_en (chan_en),
    .src_req (src_req),
    .src_ack (src_ack),
    .src_din (src_din),
    .snk_req (snk_req),
    .snk_ack (snk_ack),
    .dout    (dout),
    .dout_id (dout_id)
`ifdef RR_ARB_STATS_EN
    ,
    .grant_count   (grant_count),
    .timeout_count (timeout_count)
`endif
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit cmp_on = 1'b0;
  bit snk_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- source and sink behaviour ----------------
  int mode[N];
  int n_acks[N];
  int late_run[N];

  initial begin
    src_ack = '0;
    src_din = '0;
    snk_req = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        logic          a;
        logic [DW-1:0] d;
        a = 1'b0;
        d = DW'(10 * (i + 1) + n_acks[i]);
        case (mode[i])
          M_IMM:   a = src_req[i];
          M_NEVER: a = 1'b0;
          M_LATE: begin
            if (src_req[i] === 1'b1) late_run[i]++;
            else begin
              a = (late_run[i] == TO);
              late_run[i] = 0;
            end
          end
          default: begin
            a = (src_req[i] === 1'b1) ? ($urandom_range(0, i + 1) == 0)
                                      : ($urandom_range(0, 7) == 0);
            d = $urandom;
          end
        endcase
        if (a && mode[i] != M_RAND) n_acks[i]++;
        src_ack[i] = a;
        src_din[i*DW +: DW] = d;
      end
      if (snk_rand) snk_req = ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- behavioural model ----------------
  // The arbiter is described as a sequence of grants: pick a channel, wait for its
  // ack up to TO cycles plus one grace cycle, then wait for the sink and pulse ack.
  logic [N-1:0]   e_req  = '0;
  logic           e_ack  = 1'b0;
  logic [DW-1:0]  e_dout = '0;
  logic [IDW-1:0] e_id   = '0;
  int             m_ptr  = 0;
  bit             m_abort;
  logic [31:0]    m_grants = '0;
  logic [31:0]    m_touts  = '0;

  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_abort  = 1'b1;
      e_req    = '0;
      e_ack    = 1'b0;
      e_dout   = '0;
      e_id     = '0;
      m_ptr    = 0;
      m_grants = '0;
      m_touts  = '0;
    end
  endtask

  function automatic int first_enabled(input logic [N-1:0] en, input int from);
    for (int k = 0; k < N; k++)
      if (en[(from + k) % N] === 1'b1) return (from + k) % N;
    return -1;
  endfunction

  task automatic model_grant();
    int            sel;
    bit            got;
    logic [DW-1:0] cap;
    sel = -1;
    got = 1'b0;
    cap = '0;
    while (sel < 0) begin
      step();
      if (m_abort) return;
      sel = first_enabled(chan_en, m_ptr);
    end
    m_ptr = sel;
    e_req = N'(1) << sel;
    for (int k = 0; k < TO && !got; k++) begin
      step();
      if (m_abort) return;
      if (src_ack[sel] === 1'b1) begin
        got = 1'b1;
        cap = src_din[sel*DW +: DW];
      end
    end
    e_req = '0;
    if (!got) begin
      step();
      if (m_abort) return;
      if (src_ack[sel] === 1'b1) begin
        got = 1'b1;
        cap = src_din[sel*DW +: DW];
      end
    end
    m_ptr = (sel + 1) % N;
    if (!got) begin
      m_touts = m_touts + 32'd1;
      return;
    end
    e_dout   = cap;
    e_id     = IDW'(sel);
    m_grants = m_grants + 32'd1;
    do begin
      step();
      if (m_abort) return;
    end while (snk_req !== 1'b1);
    e_ack = 1'b1;
    step();
    if (m_abort) return;
    e_ack = 1'b0;
  endtask

  initial begin
    forever begin
      m_abort = 1'b0;
      model_grant();
    end
  end

  // ---------------- compare and monitor ----------------
  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            cyc;
  } deliv_t;

  deliv_t got_q[$];
  int     req_run[N];
  int     last_run[N];

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        check("src_req", 64'(src_req), 64'(e_req));
        check("snk_ack", 64'(snk_ack), 64'(e_ack));
        check("dout",    64'(dout),    64'(e_dout));
        check("dout_id", 64'(dout_id), 64'(e_id));
`ifdef RR_ARB_STATS_EN
        check("grant_count",   64'(grant_count),   64'(m_grants));
        check("timeout_count", 64'(timeout_count), 64'(m_touts));
`endif
      end
      if (snk_ack === 1'b1) begin
        deliv_t d;
        d.id   = int'(dout_id);
        d.data = dout;
        d.cyc  = cyc;
        got_q.push_back(d);
      end
      for (int i = 0; i < N; i++) begin
        if (src_req[i] === 1'b1) req_run[i]++;
        else begin
          if (req_run[i] > 0) last_run[i] = req_run[i];
          req_run[i] = 0;
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic setup(input int m0, input int m1, input int m2, input int m3);
    mode[0] = m0; mode[1] = m1; mode[2] = m2; mode[3] = m3;
    for (int i = 0; i < N; i++) begin
      n_acks[i]   = 0;
      late_run[i] = 0;
      last_run[i] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    cmp_on = 1'b1;
  endtask

  task automatic wait_deliv(input int n, input int budget);
    int waited;
    waited = 0;
    while (got_q.size() < n && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check("deliv_wait", 64'(got_q.size() >= n), 64'(1));
  endtask

  task automatic check_deliv(input string name, input int idx, input int id, input int data);
    if (got_q.size() > idx) begin
      check({name, "_id"},   64'(got_q[idx].id),   64'(id));
      check({name, "_data"}, 64'(got_q[idx].data), 64'(data));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_id[5];
    int exp_dt[5];

    // 1: all channels ack immediately
    setup(M_IMM, M_IMM, M_IMM, M_IMM);
    chan_en = 4'hF;
    snk_req = 1'b1;
    do_reset();
    wait_deliv(5, 60);
    exp_id = '{0, 1, 2, 3, 0};
    exp_dt = '{10, 20, 30, 40, 11};
    for (int i = 0; i < 5; i++) check_deliv("t1", i, exp_id[i], exp_dt[i]);
    for (int i = 1; i < 5; i++)
      if (got_q.size() > i) check("t1_gap", 64'(got_q[i].cyc - got_q[i-1].cyc), 64'(4));

    // 2: channel 1 never acks and is skipped after the timeout
    setup(M_IMM, M_NEVER, M_IMM, M_IMM);
    do_reset();
    wait_deliv(4, 80);
    exp_id = '{0, 2, 3, 0, 0};
    exp_dt = '{10, 30, 40, 11, 0};
    for (int i = 0; i < 4; i++) check_deliv("t2", i, exp_id[i], exp_dt[i]);
    check("t2_req1_len", 64'(last_run[1]), 64'(TO));
`ifdef RR_ARB_STATS_EN
    check("t2_timeouts", 64'(timeout_count), 64'(1));
    check("t2_grants",   64'(grant_count),   64'(4));
`endif

    // 3: channel 2 acks one cycle after its request drops
    setup(M_IMM, M_IMM, M_LATE, M_IMM);
    do_reset();
    wait_deliv(4, 80);
    exp_id = '{0, 1, 2, 3, 0};
    exp_dt = '{10, 20, 30, 40, 0};
    for (int i = 0; i < 4; i++) check_deliv("t3", i, exp_id[i], exp_dt[i]);
    check("t3_req2_len", 64'(last_run[2]), 64'(TO));
`ifdef RR_ARB_STATS_EN
    check("t3_timeouts", 64'(timeout_count), 64'(0));
    check("t3_grants",   64'(grant_count),   64'(4));
`endif

    // 4: everything disabled, then only channel 2
    setup(M_IMM, M_IMM, M_IMM, M_IMM);
    chan_en = 4'h0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t4_idle_req", 64'(src_req), 64'(0));
      check("t4_idle_ack", 64'(snk_ack), 64'(0));
    end
    chan_en = 4'b0100;
    got_q.delete();
    wait_deliv(3, 40);
    for (int i = 0; i < 3; i++) check_deliv("t4", i, 2, 30 + i);
    for (int i = 1; i < 3; i++)
      if (got_q.size() > i) check("t4_gap", 64'(got_q[i].cyc - got_q[i-1].cyc), 64'(4));

    // 5: sink stalls in HOLD, then takes exactly one token
    setup(M_IMM, M_IMM, M_IMM, M_IMM);
    chan_en = 4'hF;
    snk_req = 1'b0;
    do_reset();
    repeat (6) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t5_hold_req",  64'(src_req), 64'(0));
      check("t5_hold_dout", 64'(dout),    64'(10));
      check("t5_hold_id",   64'(dout_id), 64'(0));
    end
    snk_req = 1'b1;
    repeat (3) @(negedge clk);
    snk_req = 1'b0;
    repeat (6) @(negedge clk);
    check("t5_acks", 64'(got_q.size()), 64'(1));
    check_deliv("t5", 0, 0, 10);

    // 6: reset while holding channel 1's token drops it
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_req",  64'(src_req), 64'(0));
    check("t6_ack",  64'(snk_ack), 64'(0));
    check("t6_dout", 64'(dout),    64'(0));
    check("t6_id",   64'(dout_id), 64'(0));
    rst = 1'b0;
    got_q.delete();
    for (int i = 0; i < 10 && src_req === '0; i++) @(negedge clk);
    check("t6_first_req", 64'(src_req), 64'(4'b0001));
    snk_req = 1'b1;
    wait_deliv(1, 20);
    check_deliv("t6", 0, 0, 11);

    // 7: randomized traffic, enables, sink and occasional resets
    setup(M_RAND, M_RAND, M_RAND, M_RAND);
    snk_rand = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 15) == 0) chan_en = N'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
